// File: rtl/cunit_gen2_pkg.sv
`default_nettype none
// ============================================================================
// Module   : cunit_pkg
// Purpose  : Shared opcodes, FSM state codes, ALU selects and IR field layout
//            for the second-generation multicycle control unit.
// Revision : 1.0  initial release
// ============================================================================
package cunit_pkg;

    localparam logic [3:0] OP_NOOP  = 4'd0;
    localparam logic [3:0] OP_STORE = 4'd1;
    localparam logic [3:0] OP_LOAD  = 4'd2;
    localparam logic [3:0] OP_ADD   = 4'd3;
    localparam logic [3:0] OP_SUB   = 4'd4;
    localparam logic [3:0] OP_HALT  = 4'd5;
    localparam logic [3:0] OP_JPZ   = 4'd6;

    typedef enum logic [3:0] {
        ST_INIT   = 4'd0,
        ST_FETCH  = 4'd1,
        ST_DECODE = 4'd2,
        ST_NOOP   = 4'd3,
        ST_LOAD_A = 4'd4,
        ST_LOAD_B = 4'd5,
        ST_STORE  = 4'd6,
        ST_ADD    = 4'd7,
        ST_SUB    = 4'd8,
        ST_HALT   = 4'd9,
        ST_JPZ    = 4'd10
    } state_t;

    localparam int ALU_PASS = 0;
    localparam int ALU_ADD  = 1;
    localparam int ALU_SUB  = 2;

    localparam int IR_OP_LSB      = 12;
    localparam int IR_RA_LSB      = 8;
    localparam int IR_RB_LSB      = 4;
    localparam int IR_RW_LSB      = 0;
    localparam int IR_LD_ADDR_LSB = 4;
    localparam int IR_ST_ADDR_LSB = 0;

    // Undefined opcodes fall through to NOOP.
    function automatic state_t op_state(input logic [3:0] op);
        case (op)
            OP_STORE: return ST_STORE;
            OP_LOAD:  return ST_LOAD_A;
            OP_ADD:   return ST_ADD;
            OP_SUB:   return ST_SUB;
            OP_HALT:  return ST_HALT;
            OP_JPZ:   return ST_JPZ;
            default:  return ST_NOOP;
        endcase
    endfunction

endpackage
`default_nettype wire

// File: rtl/cunit_gen2_if.sv
`default_nettype none
// ============================================================================
// Module   : cunit_gen2_if
// Purpose  : Fetch port, datapath control set and status of the control unit.
// Revision : 1.0  initial release
// ============================================================================
interface cunit_gen2_if #(
    parameter int PC_W   = 5,
    parameter int D_AW   = 8,
    parameter int RF_AW  = 4,
    parameter int ALU_SW = 3
);
    logic              IM_req;
    logic [PC_W-1:0]   IM_addr;
    logic              IM_ack;
    logic [15:0]       IM_data;
    logic [D_AW-1:0]   D_addr;
    logic              D_wr;
    logic              RF_s;
    logic [RF_AW-1:0]  RF_W_addr;
    logic              RF_W_wr;
    logic [RF_AW-1:0]  RF_Ra_addr;
    logic              RF_Ra_rd;
    logic [RF_AW-1:0]  RF_Rb_addr;
    logic              RF_Rb_rd;
    logic [ALU_SW-1:0] Alu_s0;
    logic              Ra_zero;
    logic [15:0]       IR_Out;
    logic [PC_W-1:0]   PC_Out;
    logic [3:0]        StateO;
    logic              Halted;

    modport master (
        output IM_req, IM_addr, D_addr, D_wr, RF_s, RF_W_addr, RF_W_wr,
               RF_Ra_addr, RF_Ra_rd, RF_Rb_addr, RF_Rb_rd, Alu_s0,
               IR_Out, PC_Out, StateO, Halted,
        input  IM_ack, IM_data, Ra_zero
    );

    modport slave (
        input  IM_req, IM_addr, D_addr, D_wr, RF_s, RF_W_addr, RF_W_wr,
               RF_Ra_addr, RF_Ra_rd, RF_Rb_addr, RF_Rb_rd, Alu_s0,
               IR_Out, PC_Out, StateO, Halted,
        output IM_ack, IM_data, Ra_zero
    );
endinterface
`default_nettype wire

// File: rtl/cunit_gen2_decode.sv
`default_nettype none
// ============================================================================
// Module   : cunit_decode
// Purpose  : Moore decode of (state, IR) into the datapath control set.
// Revision : 1.0  initial release
// ============================================================================
module cunit_decode
    import cunit_pkg::*;
#(
    parameter int D_AW   = 8,
    parameter int RF_AW  = 4,
    parameter int ALU_SW = 3
) (
    input  state_t             i_state,
    input  logic [11:0]        i_ir,
    output logic [D_AW-1:0]    o_d_addr,
    output logic               o_d_wr,
    output logic               o_rf_s,
    output logic [RF_AW-1:0]   o_rf_w_addr,
    output logic               o_rf_w_wr,
    output logic [RF_AW-1:0]   o_rf_ra_addr,
    output logic               o_rf_ra_rd,
    output logic [RF_AW-1:0]   o_rf_rb_addr,
    output logic               o_rf_rb_rd,
    output logic [ALU_SW-1:0]  o_alu_s0
);
    logic [7:0] w_ld_addr, w_st_addr;
    logic [3:0] w_ra, w_rb, w_rw;

    // Full-width fields first; outputs keep only their low bits.
    assign w_ld_addr = i_ir[IR_LD_ADDR_LSB +: 8];
    assign w_st_addr = i_ir[IR_ST_ADDR_LSB +: 8];
    assign w_ra      = i_ir[IR_RA_LSB +: 4];
    assign w_rb      = i_ir[IR_RB_LSB +: 4];
    assign w_rw      = i_ir[IR_RW_LSB +: 4];

    always_comb begin
        o_d_addr     = '0;
        o_d_wr       = 1'b0;
        o_rf_s       = 1'b0;
        o_rf_w_addr  = '0;
        o_rf_w_wr    = 1'b0;
        o_rf_ra_addr = '0;
        o_rf_ra_rd   = 1'b0;
        o_rf_rb_addr = '0;
        o_rf_rb_rd   = 1'b0;
        o_alu_s0     = ALU_SW'(ALU_PASS);
        case (i_state)
            ST_LOAD_A: o_d_addr = w_ld_addr[D_AW-1:0];
            ST_LOAD_B: begin
                o_d_addr    = w_ld_addr[D_AW-1:0];
                o_rf_s      = 1'b1;
                o_rf_w_addr = w_rw[RF_AW-1:0];
                o_rf_w_wr   = 1'b1;
            end
            ST_STORE: begin
                o_d_addr     = w_st_addr[D_AW-1:0];
                o_d_wr       = 1'b1;
                o_rf_ra_addr = w_ra[RF_AW-1:0];
                o_rf_ra_rd   = 1'b1;
            end
            ST_ADD, ST_SUB: begin
                o_rf_ra_addr = w_ra[RF_AW-1:0];
                o_rf_ra_rd   = 1'b1;
                o_rf_rb_addr = w_rb[RF_AW-1:0];
                o_rf_rb_rd   = 1'b1;
                o_alu_s0     = (i_state == ST_ADD) ? ALU_SW'(ALU_ADD) : ALU_SW'(ALU_SUB);
                o_rf_w_addr  = w_rw[RF_AW-1:0];
                o_rf_w_wr    = 1'b1;
            end
            ST_JPZ: begin
                o_rf_ra_addr = w_ra[RF_AW-1:0];
                o_rf_ra_rd   = 1'b1;
            end
            default: ;
        endcase
    end
endmodule
`default_nettype wire

// File: rtl/cunit_gen2.sv
`default_nettype none
// ============================================================================
// Module   : cunit_gen2
// Purpose  : Multicycle control unit: PC, IR, control FSM and req/ack fetch.
// Revision : 1.0  initial release
// ============================================================================
module cunit_gen2
    import cunit_pkg::*;
#(
    parameter int PC_W   = 5,
    parameter int D_AW   = 8,
    parameter int RF_AW  = 4,
    parameter int ALU_SW = 3
) (
    input  wire logic     Clk,
    input  wire logic     Reset,
    cunit_gen2_if.master  bus
);
    state_t          r_state, w_state_nxt;
    logic [PC_W-1:0] r_pc;
    logic [15:0]     r_ir;

    always_ff @(posedge Clk or posedge Reset) begin
        if (Reset) begin
            r_state <= ST_INIT;
            r_pc    <= '0;
            r_ir    <= '0;
        end else begin
            r_state <= w_state_nxt;
            if (r_state == ST_FETCH && bus.IM_ack) begin
                r_ir <= bus.IM_data;
                r_pc <= r_pc + 1'b1;
            end else if (r_state == ST_JPZ && bus.Ra_zero) begin
                // PC was already advanced at fetch; only a taken jump rewrites it.
                r_pc <= r_ir[PC_W-1:0];
            end
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            ST_INIT:   w_state_nxt = ST_FETCH;
            ST_FETCH:  if (bus.IM_ack) w_state_nxt = ST_DECODE;
            ST_DECODE: w_state_nxt = op_state(r_ir[IR_OP_LSB +: 4]);
            ST_LOAD_A: w_state_nxt = ST_LOAD_B;
            ST_HALT:   w_state_nxt = ST_HALT;
            default:   w_state_nxt = ST_FETCH;
        endcase
    end

    cunit_decode #(
        .D_AW   (D_AW),
        .RF_AW  (RF_AW),
        .ALU_SW (ALU_SW)
    ) u_decode (
        .i_state      (r_state),
        .i_ir         (r_ir[11:0]),
        .o_d_addr     (bus.D_addr),
        .o_d_wr       (bus.D_wr),
        .o_rf_s       (bus.RF_s),
        .o_rf_w_addr  (bus.RF_W_addr),
        .o_rf_w_wr    (bus.RF_W_wr),
        .o_rf_ra_addr (bus.RF_Ra_addr),
        .o_rf_ra_rd   (bus.RF_Ra_rd),
        .o_rf_rb_addr (bus.RF_Rb_addr),
        .o_rf_rb_rd   (bus.RF_Rb_rd),
        .o_alu_s0     (bus.Alu_s0)
    );

    assign bus.IM_req  = (r_state == ST_FETCH);
    assign bus.IM_addr = r_pc;
    assign bus.IR_Out  = r_ir;
    assign bus.PC_Out  = r_pc;
    assign bus.StateO  = r_state;
    assign bus.Halted  = (r_state == ST_HALT);
endmodule
`default_nettype wire

// File: tb/tb_cunit_gen2.sv
`default_nettype none
// ============================================================================
// Module   : tb_cunit_gen2
// Purpose  : Directed bench with an instruction-level expected-output queue.
// Revision : 1.0  initial release
// ============================================================================
module tb_cunit_gen2;
    localparam int PC_W = 5, D_AW = 8, RF_AW = 4, ALU_SW = 3;

    typedef struct packed {
        logic [3:0] st;
        logic       req;
        logic [7:0] da;
        logic       dwr;
        logic       rfs;
        logic [3:0] wa;
        logic       wwr;
        logic [3:0] ra;
        logic       rard;
        logic [3:0] rb;
        logic       rbrd;
        logic [2:0] alu;
        logic       halt;
    } vec_t;

    logic clk = 1'b0;
    logic rst = 1'b0;
    int   n_checks = 0;
    int   n_fail   = 0;

    always #5 clk = ~clk;

    cunit_gen2_if #(.PC_W(PC_W), .D_AW(D_AW), .RF_AW(RF_AW), .ALU_SW(ALU_SW)) bus ();

    cunit_gen2 #(.PC_W(PC_W), .D_AW(D_AW), .RF_AW(RF_AW), .ALU_SW(ALU_SW)) dut (
        .Clk   (clk),
        .Reset (rst),
        .bus   (bus)
    );

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s actual=%0h required=%0h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic vec_t mk(input logic [3:0] st);
        vec_t v;
        v = '0;
        v.st = st;
        return v;
    endfunction

    // Expected outputs per cycle; an empty queue means FETCH (or HALT once halted).
    vec_t            q[$];
    logic [PC_W-1:0] m_pc;
    logic [15:0]     m_ir;
    bit              m_halted = 1'b0;

    function automatic void push_instr(input logic [15:0] ir);
        vec_t v;
        q.push_back(mk(4'd2));
        case (ir[15:12])
            4'd1: begin
                v = mk(4'd6); v.da = ir[7:0]; v.ra = ir[11:8]; v.rard = 1'b1; v.dwr = 1'b1;
                q.push_back(v);
            end
            4'd2: begin
                v = mk(4'd4); v.da = ir[11:4];
                q.push_back(v);
                v = mk(4'd5); v.da = ir[11:4]; v.rfs = 1'b1; v.wa = ir[3:0]; v.wwr = 1'b1;
                q.push_back(v);
            end
            4'd3, 4'd4: begin
                v = mk((ir[15:12] == 4'd3) ? 4'd7 : 4'd8);
                v.ra = ir[11:8]; v.rb = ir[7:4]; v.rard = 1'b1; v.rbrd = 1'b1;
                v.alu = (ir[15:12] == 4'd3) ? 3'd1 : 3'd2;
                v.wa = ir[3:0]; v.wwr = 1'b1;
                q.push_back(v);
            end
            4'd5: m_halted = 1'b1;
            4'd6: begin
                v = mk(4'd10); v.ra = ir[11:8]; v.rard = 1'b1;
                q.push_back(v);
            end
            default: q.push_back(mk(4'd3));
        endcase
    endfunction

    always @(posedge clk or posedge rst) begin : model
        vec_t h;
        if (rst) begin
            q.delete();
            q.push_back(mk(4'd0));
            m_pc = '0;
            m_ir = '0;
            m_halted = 1'b0;
        end else if (q.size() > 0) begin
            h = q.pop_front();
            if (h.st == 4'd10 && bus.Ra_zero) m_pc = m_ir[PC_W-1:0];
        end else if (!m_halted && bus.IM_ack) begin
            m_ir = bus.IM_data;
            m_pc = m_pc + 1'b1;
            push_instr(bus.IM_data);
        end
    end

    always @(negedge clk) begin : compare
        vec_t e, a;
        if (q.size() > 0) e = q[0];
        else if (m_halted) begin e = mk(4'd9); e.halt = 1'b1; end
        else begin e = mk(4'd1); e.req = 1'b1; end
        a.st = bus.StateO;       a.req = bus.IM_req;       a.da = bus.D_addr;
        a.dwr = bus.D_wr;        a.rfs = bus.RF_s;         a.wa = bus.RF_W_addr;
        a.wwr = bus.RF_W_wr;     a.ra = bus.RF_Ra_addr;    a.rard = bus.RF_Ra_rd;
        a.rb = bus.RF_Rb_addr;   a.rbrd = bus.RF_Rb_rd;    a.alu = bus.Alu_s0;
        a.halt = bus.Halted;
        chk("ctl_vector", 64'(a), 64'(e));
        chk("pc_ir", {bus.IM_addr, bus.PC_Out, bus.IR_Out}, {m_pc, m_pc, m_ir});
    end

    task automatic step();
        @(posedge clk);
        #2;
    endtask

    task automatic wait_fetch();
        int n = 0;
        while (!bus.IM_req && n < 20) begin
            step();
            n++;
        end
        chk("fetch_timeout", 64'(n >= 20), 64'd0);
    endtask

    task automatic do_fetch(input logic [15:0] d, input int waits);
        wait_fetch();
        repeat (waits) step();
        bus.IM_ack  = 1'b1;
        bus.IM_data = d;
        step();
        bus.IM_ack  = 1'b0;
        bus.IM_data = 16'hDEAD;
    endtask

    initial begin
        bus.IM_ack  = 1'b0;
        bus.IM_data = 16'h0000;
        bus.Ra_zero = 1'b0;
        #1 rst = 1'b1;
        repeat (2) @(posedge clk);
        #2 rst = 1'b0;
        step();
        chk("first_fetch_state", bus.StateO, 4'd1);

        // Reset lands mid-FETCH while an ack is pending.
        bus.IM_ack  = 1'b1;
        bus.IM_data = 16'h3124;
        rst = 1'b1;
        #1;
        chk("reset_state", bus.StateO, 4'd0);
        chk("reset_req", bus.IM_req, 1'b0);
        step();
        chk("reset_ir", bus.IR_Out, 16'h0000);
        bus.IM_ack = 1'b0;
        rst = 1'b0;
        #1 chk("init_after_release", bus.StateO, 4'd0);
        step();
        chk("fetch_after_release", bus.StateO, 4'd1);
        chk("fetch_addr0", bus.IM_addr, 5'd0);

        do_fetch(16'h2053, 3);
        chk("load_decode", bus.StateO, 4'd2);
        step();
        chk("load_a_state", bus.StateO, 4'd4);
        chk("load_a_daddr", bus.D_addr, 8'h05);
        step();
        chk("load_b_ctl", {bus.StateO, bus.RF_s, bus.RF_W_addr, bus.RF_W_wr}, {4'd5, 1'b1, 4'd3, 1'b1});
        step();
        chk("load_done", {bus.StateO, bus.PC_Out}, {4'd1, 5'd1});

        do_fetch(16'h3124, 0);
        step();
        chk("add_ctl", {bus.StateO, bus.RF_Ra_addr, bus.RF_Rb_addr, bus.RF_W_addr, bus.Alu_s0, bus.RF_W_wr, bus.RF_s},
            {4'd7, 4'd1, 4'd2, 4'd4, 3'd1, 1'b1, 1'b0});
        step();
        chk("add_one_cycle", {bus.StateO, bus.RF_W_wr}, {4'd1, 1'b0});

        do_fetch(16'h0000, 1);
        wait_fetch();
        chk("pc_before_jpz", bus.IM_addr, 5'd3);

        bus.Ra_zero = 1'b1;
        do_fetch(16'h6207, 2);
        wait_fetch();
        chk("jpz_taken", bus.IM_addr, 5'd7);
        do_fetch(16'h6203, 0);
        wait_fetch();
        chk("jpz_back", bus.IM_addr, 5'd3);
        bus.Ra_zero = 1'b0;
        do_fetch(16'h6207, 0);
        wait_fetch();
        chk("jpz_not_taken", bus.IM_addr, 5'd4);

        bus.Ra_zero = 1'b1;
        do_fetch(16'h621F, 0);
        wait_fetch();
        chk("jpz_to_31", bus.IM_addr, 5'd31);
        bus.Ra_zero = 1'b0;
        do_fetch(16'h0000, 0);
        wait_fetch();
        chk("pc_wrap", bus.IM_addr, 5'd0);

        do_fetch(16'hF123, 0);
        step();
        chk("undef_as_noop", bus.StateO, 4'd3);
        do_fetch(16'h1A5C, 1);
        step();
        chk("store_ctl", {bus.StateO, bus.D_addr, bus.RF_Ra_addr, bus.D_wr, bus.RF_Ra_rd},
            {4'd6, 8'h5C, 4'hA, 1'b1, 1'b1});
        do_fetch(16'h4567, 0);
        step();
        chk("sub_ctl", {bus.StateO, bus.Alu_s0, bus.RF_Ra_addr, bus.RF_Rb_addr, bus.RF_W_addr},
            {4'd8, 3'd2, 4'd5, 4'd6, 4'd7});
        wait_fetch();
        bus.Ra_zero = 1'b1;
        do_fetch(16'h6203, 0);
        wait_fetch();
        chk("jpz_tight_loop", bus.IM_addr, 5'd3);
        bus.Ra_zero = 1'b0;

        do_fetch(16'h5000, 0);
        step();
        chk("halt_state", {bus.StateO, bus.Halted}, {4'd9, 1'b1});
        for (int i = 0; i < 24; i++) begin
            bus.IM_ack  = ~bus.IM_ack;
            bus.IM_data = 16'h3124;
            step();
            if (i % 6 == 0) chk("halt_no_req", bus.IM_req, 1'b0);
        end
        bus.IM_ack = 1'b0;
        chk("halt_sticky", bus.StateO, 4'd9);

        rst = 1'b1;
        #1;
        chk("reset_from_halt", {bus.PC_Out, bus.Halted, bus.StateO}, {5'd0, 1'b0, 4'd0});
        step();
        rst = 1'b0;
        repeat (3) step();
        chk("fetch_after_halt_reset", {bus.StateO, bus.IM_addr}, {4'd1, 5'd0});

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end
endmodule
`default_nettype wire
